// File: rtl/spi_mem_ctrl_pkg.sv
// Shared definitions for the SPI memory front end: command bytes, access
// size encodings, controller states and the alignment rule.
package spi_mem_ctrl_pkg;

   localparam logic [7:0] READ_CMD  = 8'h03;
   localparam logic [7:0] WRITE_CMD = 8'h02;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   // Size 3 is handled as a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (size == SZ_HALF)
         bad = lo[0];
      else if (size != SZ_BYTE)
         bad = (lo != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// CPU-side load/store bus plus the SPI master control bus of spi_mem_ctrl.
interface spi_mem_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_err;
   logic        buf_flush;
   logic        spi_start;
   logic        spi_write;
   logic [31:0] spi_cmd_addr;
   logic [5:0]  spi_data_len;
   logic [31:0] spi_wdata;
   logic [31:0] spi_rdata;
   logic        spi_done;

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_size, mem_wdata, buf_flush,
      input  spi_rdata, spi_done,
      output mem_rdata, mem_ready, mem_err,
      output spi_start, spi_write, spi_cmd_addr, spi_data_len, spi_wdata
   );

   modport master (
      output mem_req, mem_we, mem_addr, mem_size, mem_wdata, buf_flush,
      output spi_rdata, spi_done,
      input  mem_rdata, mem_ready, mem_err,
      input  spi_start, spi_write, spi_cmd_addr, spi_data_len, spi_wdata
   );
endinterface

// File: rtl/spi_mem_ctrl_lane_fmt.sv
// Combinational byte-lane formatting: CPU store data to SPI byte order
// (first byte in [31:24]) and SPI read word to little-endian CPU order.
module spi_mem_lane_fmt
   import spi_mem_ctrl_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [5:0]  len_o,
   output logic [31:0] rdata_o
);

   always_comb begin
      wdata_o = {wdata_i[7:0], wdata_i[15:8], wdata_i[23:16], wdata_i[31:24]};
      len_o   = 6'd32;
      case (size_i)
         SZ_BYTE: begin
            wdata_o = {wdata_i[7:0], 24'h0};
            len_o   = 6'd8;
         end
         SZ_HALF: begin
            wdata_o = {wdata_i[7:0], wdata_i[15:8], 16'h0};
            len_o   = 6'd16;
         end
         default: ;
      endcase
   end

   assign rdata_o = {rdata_i[7:0], rdata_i[15:8], rdata_i[23:16], rdata_i[31:24]};

endmodule

// File: rtl/spi_mem_ctrl.sv
// Memory-mapped front end for the SPI master: single load/store requests
// become 0x03/0x02 SPI transactions, with a one-word read buffer.
module spi_mem_ctrl
   import spi_mem_ctrl_pkg::*;
#(
   parameter bit BUF_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_mem_ctrl_if.slave  bus
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [21:0] word_q, word_d;
   logic [31:0] rdata_q, rdata_d;
   logic        buf_valid_q, buf_valid_d;
   logic [21:0] buf_addr_q, buf_addr_d;
   logic        spi_write_q, spi_write_d;
   logic [31:0] spi_cmd_addr_q, spi_cmd_addr_d;
   logic [5:0]  spi_len_q, spi_len_d;
   logic [31:0] spi_wdata_q, spi_wdata_d;

   logic [31:0] fmt_wdata;
   logic [5:0]  fmt_len;
   logic [31:0] fmt_rdata;
   logic        req_mis;
   logic        req_hit;

   spi_mem_lane_fmt u_fmt (
      .size_i  (bus.mem_size),
      .wdata_i (bus.mem_wdata),
      .rdata_i (bus.spi_rdata),
      .wdata_o (fmt_wdata),
      .len_o   (fmt_len),
      .rdata_o (fmt_rdata)
   );

   assign req_mis = is_misaligned(bus.mem_size, bus.mem_addr[1:0]);
   assign req_hit = buf_valid_q && (buf_addr_q == bus.mem_addr[23:2]);

   // Buffer data is rdata_q itself: it only changes on load completions,
   // and every successful load refills the buffer with that same value.
   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      err_d          = err_q;
      word_d         = word_q;
      rdata_d        = rdata_q;
      buf_valid_d    = buf_valid_q;
      buf_addr_d     = buf_addr_q;
      spi_write_d    = spi_write_q;
      spi_cmd_addr_d = spi_cmd_addr_q;
      spi_len_d      = spi_len_q;
      spi_wdata_d    = spi_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.mem_req) begin
               we_d   = bus.mem_we;
               err_d  = req_mis;
               word_d = bus.mem_addr[23:2];
               if (bus.mem_we && req_hit)
                  buf_valid_d = 1'b0;
               if (req_mis) begin
                  state_d = ST_RESP;
               end else if (!bus.mem_we && BUF_EN && req_hit) begin
                  state_d = ST_RESP;
               end else begin
                  state_d     = ST_ISSUE;
                  spi_write_d = bus.mem_we;
                  if (bus.mem_we) begin
                     spi_cmd_addr_d = {WRITE_CMD, bus.mem_addr};
                     spi_len_d      = fmt_len;
                     spi_wdata_d    = fmt_wdata;
                  end else begin
                     spi_cmd_addr_d = {READ_CMD, bus.mem_addr[23:2], 2'b00};
                     spi_len_d      = 6'd32;
                     spi_wdata_d    = '0;
                  end
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.spi_done) begin
               state_d = ST_RESP;
               if (!we_q)
                  rdata_d = fmt_rdata;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!we_q && !err_q) begin
               buf_valid_d = BUF_EN;
               buf_addr_d  = word_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.buf_flush)
         buf_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         we_q           <= 1'b0;
         err_q          <= 1'b0;
         word_q         <= '0;
         rdata_q        <= '0;
         buf_valid_q    <= 1'b0;
         buf_addr_q     <= '0;
         spi_write_q    <= 1'b0;
         spi_cmd_addr_q <= '0;
         spi_len_q      <= '0;
         spi_wdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         we_q           <= we_d;
         err_q          <= err_d;
         word_q         <= word_d;
         rdata_q        <= rdata_d;
         buf_valid_q    <= buf_valid_d;
         buf_addr_q     <= buf_addr_d;
         spi_write_q    <= spi_write_d;
         spi_cmd_addr_q <= spi_cmd_addr_d;
         spi_len_q      <= spi_len_d;
         spi_wdata_q    <= spi_wdata_d;
      end
   end

   assign bus.mem_rdata    = rdata_q;
   assign bus.mem_ready    = (state_q == ST_RESP);
   assign bus.mem_err      = (state_q == ST_RESP) && err_q;
   assign bus.spi_start    = (state_q == ST_ISSUE);
   assign bus.spi_write    = spi_write_q;
   assign bus.spi_cmd_addr = spi_cmd_addr_q;
   assign bus.spi_data_len = spi_len_q;
   assign bus.spi_wdata    = spi_wdata_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: directed plan steps then random
// loads/stores against a byte-array memory model with a one-word buffer.
module tb_spi_mem_ctrl;

   logic clk;
   logic rst_n;

   spi_mem_ctrl_if bus ();

   spi_mem_ctrl #(.BUF_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned tests = 0;
   int unsigned fails = 0;

   // SPI-side memory (acted on by the SPI slave model) and reference memory
   logic [7:0]  spi_mem [1024];
   logic [7:0]  ref_mem [1024];
   bit          m_valid;
   logic [21:0] m_word;
   logic [31:0] m_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".rdata"}, bus.mem_rdata, 32'h0);
      check({tag, ".ready"}, {31'h0, bus.mem_ready}, 32'h0);
      check({tag, ".err"}, {31'h0, bus.mem_err}, 32'h0);
      check({tag, ".start"}, {31'h0, bus.spi_start}, 32'h0);
      check({tag, ".write"}, {31'h0, bus.spi_write}, 32'h0);
      check({tag, ".cmd"}, bus.spi_cmd_addr, 32'h0);
      check({tag, ".len"}, {26'h0, bus.spi_data_len}, 32'h0);
      check({tag, ".wdata"}, bus.spi_wdata, 32'h0);
   endtask

   function automatic logic [31:0] ref_le_word(input logic [23:0] a);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = ref_mem[{a[9:2], 2'b00} + i];
      return r;
   endfunction

   // One CPU request, entered with the DUT in IDLE; leaves it in IDLE.
   task automatic do_req(input bit we, input logic [1:0] size, input logic [23:0] addr,
                         input logic [31:0] wdata, input bit flush_resp, input bit rst_wait);
      bit          mis, hit, exp_spi;
      int          nb, n, starts, done_n, ready_n, lat;
      logic [31:0] exp_cmd, exp_w, r;
      logic [5:0]  exp_len;
      logic [9:0]  base;

      mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'b00);
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      hit = !we && m_valid && (m_word == addr[23:2]);
      exp_spi = !mis && !hit;
      exp_len = we ? 6'(nb * 8) : 6'd32;
      exp_cmd = we ? {8'h02, addr} : {8'h03, addr[23:2], 2'b00};
      exp_w   = '0;
      if (we)
         for (int i = 0; i < nb; i++)
            exp_w[31 - 8*i -: 8] = wdata[8*i +: 8];

      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_addr  = addr;
      bus.mem_size  = size;
      bus.mem_wdata = wdata;
      n = 0; starts = 0; done_n = 0; ready_n = 0;
      lat = int'($urandom_range(1, 4));

      while (ready_n == 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
         bus.spi_done = 1'b0;
         if (rst_wait && starts == 1 && n == 2) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("rst_wait");
            bus.mem_req = 1'b0;
            repeat (2) begin
               @(posedge clk); #1;
               check("rst_no_ready", {31'h0, bus.mem_ready}, 32'h0);
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_after_ready", {31'h0, bus.mem_ready}, 32'h0);
            m_valid = 1'b0;
            m_rdata = '0;
            return;
         end
         if (bus.spi_start) begin
            starts++;
            check("start_cycle", n, 1);
            check("cmd_addr", bus.spi_cmd_addr, exp_cmd);
            check("data_len", {26'h0, bus.spi_data_len}, {26'h0, exp_len});
            check("spi_write", {31'h0, bus.spi_write}, {31'h0, we});
            check("spi_wdata", bus.spi_wdata, exp_w);
         end
         if (bus.mem_ready) begin
            ready_n = n;
         end else if (starts == 1 && done_n == 0 && n == 1 + lat) begin
            check("cmd_stable", bus.spi_cmd_addr, exp_cmd);
            base = bus.spi_cmd_addr[9:0];
            if (bus.spi_write) begin
               for (int i = 0; i < int'(bus.spi_data_len) / 8; i++)
                  spi_mem[base + 10'(i)] = bus.spi_wdata[31 - 8*i -: 8];
            end else begin
               for (int i = 0; i < 4; i++)
                  r[31 - 8*i -: 8] = spi_mem[base + 10'(i)];
               bus.spi_rdata = r;
            end
            bus.spi_done = 1'b1;
            done_n = n;
         end
      end

      check("ready_seen", {31'h0, ready_n != 0}, 32'h1);
      if (ready_n == 0) begin
         bus.mem_req = 1'b0;
         return;
      end

      // Reference model update
      if (we && m_valid && m_word == addr[23:2])
         m_valid = 1'b0;
      if (!mis) begin
         if (we) begin
            for (int i = 0; i < nb; i++)
               ref_mem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
         end else begin
            m_rdata = ref_le_word(addr);
            m_valid = 1'b1;
            m_word  = addr[23:2];
         end
      end
      if (flush_resp)
         m_valid = 1'b0;

      check("ready_cycle", ready_n, exp_spi ? done_n + 1 : 1);
      check("start_count", starts, exp_spi ? 1 : 0);
      check("mem_err", {31'h0, bus.mem_err}, {31'h0, mis});
      check("mem_rdata", bus.mem_rdata, m_rdata);

      if (flush_resp)
         bus.buf_flush = 1'b1;
      bus.mem_req = 1'b0;
      @(posedge clk); #1;
      bus.buf_flush = 1'b0;
      check("ready_pulse", {31'h0, bus.mem_ready}, 32'h0);
   endtask

   initial begin
      logic [23:0] a;
      logic [1:0]  sz;
      bit          w;

      for (int i = 0; i < 1024; i++) begin
         spi_mem[i] = 8'($urandom);
         ref_mem[i] = spi_mem[i];
      end
      spi_mem[10'h104] = 8'hAA; spi_mem[10'h105] = 8'hBB;
      spi_mem[10'h106] = 8'hCC; spi_mem[10'h107] = 8'hDD;
      for (int i = 10'h104; i < 10'h108; i++)
         ref_mem[i] = spi_mem[i];
      m_valid = 1'b0; m_word = '0; m_rdata = '0;

      rst_n         = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_size  = '0;
      bus.mem_wdata = '0;
      bus.buf_flush = 1'b0;
      bus.spi_rdata = '0;
      bus.spi_done  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_req(1'b0, 2'd2, 24'h000104, 32'h0, 1'b0, 1'b0);
      check("first_load_data", bus.mem_rdata, 32'hDDCCBBAA);
      do_req(1'b0, 2'd1, 24'h000106, 32'h0, 1'b0, 1'b0);
      check("hit_data", bus.mem_rdata, 32'hDDCCBBAA);
      do_req(1'b1, 2'd0, 24'h000105, 32'h0000005A, 1'b0, 1'b0);
      do_req(1'b0, 2'd2, 24'h000104, 32'h0, 1'b0, 1'b0);
      check("after_store_data", bus.mem_rdata, 32'hDDCC5AAA);
      do_req(1'b1, 2'd1, 24'h000003, 32'h00001234, 1'b0, 1'b0);
      do_req(1'b0, 2'd2, 24'h000200, 32'h0, 1'b1, 1'b0);
      do_req(1'b0, 2'd2, 24'h000200, 32'h0, 1'b0, 1'b0);

      // spi_done outside WAIT has no effect
      bus.spi_done = 1'b1;
      @(posedge clk); #1;
      bus.spi_done = 1'b0;
      check("stray_done_ready", {31'h0, bus.mem_ready}, 32'h0);
      @(posedge clk); #1;
      check("stray_done_start", {31'h0, bus.spi_start}, 32'h0);

      do_req(1'b0, 2'd2, 24'h000300, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 2'd2, 24'h000104, 32'h0, 1'b0, 1'b0);

      for (int k = 0; k < 80; k++) begin
         a  = {14'h0, 3'($urandom_range(0, 7)), 5'h0, 2'($urandom)};
         a[7:5] = 3'($urandom);
         sz = 2'($urandom);
         w  = ($urandom_range(0, 2) == 0);
         do_req(w, sz, a, $urandom, ($urandom_range(0, 9) == 0), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Memory-mapped front end for the SPI master. It converts single CPU load/store requests into SPI command/address/data transactions: 0x03 read and 0x02 write, with a 24-bit address. It also does little-endian byte-lane formatting and keeps a one-word read buffer. It sits between the core's data/instruction bus and the SPI master, driving that block's start/cmd_addr/data_len/data_in and consuming its data_out/done.

## Interface
- READ_CMD, 8'h03, command byte for reads
- WRITE_CMD, 8'h02, command byte for writes
- BUF_EN, 1, enable the one-word read buffer (0 = every read goes to SPI)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- mem_req  input  1  request valid; held by CPU until mem_ready
- mem_we  input  1  1 = store, 0 = load
- mem_addr  input  24  byte address
- mem_size  input  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- mem_wdata  input  32  store value, right-justified
- mem_rdata  output  32  aligned little-endian word containing the addressed bytes
- mem_ready  output  1  one-cycle completion pulse
- mem_err  output  1  valid with mem_ready; misaligned access
- buf_flush  input  1  invalidate read buffer
- spi_start  output  1  one-cycle start pulse to SPI master
- spi_write  output  1  write_enable to SPI master
- spi_cmd_addr  output  32  {cmd, addr[23:0]}
- spi_data_len  output  6  data bits: 8, 16 or 32
- spi_wdata  output  32  write data, first byte on SPI in [31:24]
- spi_rdata  input  32  SPI master data_out
- spi_done  input  1  SPI master one-cycle done pulse

## Operation
- Reset values:
  - All outputs 0.
  - buf_valid 0, state IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, mem_req=1: the request is captured into registers.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0): go to RESP with err. No SPI activity.
  - Load, BUF_EN=1, buf_valid=1, buf_addr==addr[23:2]: hit. Go to RESP with buf_data.
  - Otherwise go to ISSUE.
- ISSUE: spi_start=1 for exactly one cycle, together with spi_write, spi_cmd_addr, spi_data_len and spi_wdata. Go to WAIT.
  - All spi_* operands stay stable from ISSUE until spi_done.
- WAIT: hold until spi_done=1, then go to RESP.
- RESP: mem_ready=1 for one cycle (plus mem_err if misaligned). Go to IDLE. mem_rdata holds until the next RESP.
- Loads always fetch the whole aligned word:
  - spi_cmd_addr = {READ_CMD, addr[23:2], 2'b00}, spi_data_len = 32.
  - mem_rdata = {r[7:0], r[15:8], r[23:16], r[31:24]}, where r = spi_rdata.
  - The buffer fills with mem_rdata and addr[23:2]; buf_valid = 1.
- Stores:
  - spi_cmd_addr = {WRITE_CMD, addr[23:0]}.
  - Byte: len 8, spi_wdata[31:24] = wdata[7:0].
  - Half: len 16, [31:24] = wdata[7:0], [23:16] = wdata[15:8].
  - Word: len 32, full byte swap of wdata.
  - Unused low spi_wdata bits are 0. mem_rdata is unchanged.
- A store whose word matches buf_addr clears buf_valid at acceptance.
- buf_flush clears buf_valid in any state. If it coincides with a fill in RESP, flush wins (buf_valid = 0).
- mem_req is sampled only in IDLE. Requests during other states are ignored until the controller returns to IDLE. The CPU keeps mem_req high until mem_ready.
- The controller does not track the SPI master's first-access init delay. WAIT simply lasts longer.

## Timing
- Cycle 0: request accepted in IDLE.
- Hit or misaligned: mem_ready at cycle 1.
- Miss or store:
  - spi_start at cycle 1.
  - mem_ready one cycle after the cycle in which spi_done=1.
- Back-to-back: the next request is accepted the cycle after mem_ready (IDLE). The minimum hit-to-hit spacing is 2 cycles.
- spi_done while not in WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE, buf_valid cleared, no mem_ready. The SPI master shares rst_n.

## Structure
- Shared package: command constants READ_CMD/WRITE_CMD, size encodings, and state encoding.
- Sub-module spi_mem_lane_fmt (combinational byte-swap/justify for both directions). The buffer and FSM stay in the top module.

## Test plan
- Word load at 0x000104; SPI model returns 0xAABBCCDD:
  - spi_cmd_addr = 0x03000104, len 32.
  - mem_rdata = 0xDDCCBBAA, mem_ready one cycle after spi_done.
- Repeat the load at 0x000106 (half): no spi_start, mem_ready at cycle 1, mem_rdata = 0xDDCCBBAA.
- Byte store of 0x5A to 0x000105:
  - spi_cmd_addr = 0x02000105, len 8, spi_wdata = 0x5A000000.
  - Buffer invalidated: the next load of 0x000104 issues SPI.
- Half store of 0x1234 to 0x000003: mem_ready + mem_err at cycle 1, no spi_start.
- Load 0x000200 with buf_flush asserted in the RESP cycle: a following load of 0x000200 misses.
- rst_n low during WAIT: all outputs 0, mem_ready never pulses, and the next request is accepted normally.
